// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a single-outstanding req/ack data-RAM port,
// lane-positions store data, aligns/extends load data and stalls the pipeline.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  mem_read_flag,
  input  logic                  mem_write_flag,
  input  logic                  mem_sign_ext_flag,
  input  logic [3:0]            mem_sel,
  input  logic [31:0]           mem_write_data,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  ram_req,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  input  logic                  ram_ack,
  output logic [31:0]           load_data,
  output logic                  done,
  output logic                  stall_req,
  output logic                  addr_err,
  output logic                  bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              we_q;
  logic [31:0]             wdata_q;
  logic                    read_q;
  logic                    sign_q;
  logic                    word_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [31:0]             load_q;
  logic                    addr_err_q;

  logic                    sel_byte, sel_word, is_write;
  logic                    start, misalign, accept, timeout;
  logic [7:0]              rd_byte;
  logic [31:0]             rd_ext;

  assign sel_byte = (mem_sel == 4'b0001);
  assign sel_word = (mem_sel == 4'b1111);
  assign is_write = mem_write_flag;
  assign start    = in_valid & (mem_read_flag | mem_write_flag) & (sel_byte | sel_word);
  assign misalign = start & sel_word & (mem_addr[1:0] != 2'b00);
  assign accept   = (state_q == IDLE) & start & ~misalign;

  // Byte lane select for loads uses the latched address, not the live ALU output.
  always_comb begin
    rd_byte = ram_rdata[7:0];
    case (addr_q[1:0])
      2'd0: rd_byte = ram_rdata[7:0];
      2'd1: rd_byte = ram_rdata[15:8];
      2'd2: rd_byte = ram_rdata[23:16];
      2'd3: rd_byte = ram_rdata[31:24];
      default: rd_byte = ram_rdata[7:0];
    endcase
    if (word_q)
      rd_ext = ram_rdata;
    else if (sign_q)
      rd_ext = {{24{rd_byte[7]}}, rd_byte};
    else
      rd_ext = {24'b0, rd_byte};
  end

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        if (ram_ack) begin
          state_d = FIN;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 4'b0000;
      wdata_q    <= 32'b0;
      read_q     <= 1'b0;
      sign_q     <= 1'b0;
      word_q     <= 1'b0;
      cnt_q      <= '0;
      load_q     <= 32'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_err_q <= (state_q == IDLE) & misalign;
      if (accept) begin
        addr_q  <= mem_addr;
        read_q  <= ~is_write;
        sign_q  <= mem_sign_ext_flag;
        word_q  <= sel_word;
        we_q    <= !is_write ? 4'b0000 : (sel_word ? 4'b1111 : (4'b0001 << mem_addr[1:0]));
        wdata_q <= sel_word ? mem_write_data : {4{mem_write_data[7:0]}};
      end
      if (state_q == REQ)
        cnt_q <= cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;
      // A timed-out access leaves a defined zero result rather than stale data.
      if ((state_q == REQ) && ram_ack && read_q)
        load_q <= rd_ext;
      else if (timeout)
        load_q <= 32'b0;
    end
  end

  assign ram_req   = (state_q == REQ);
  assign ram_we    = (state_q == REQ) ? we_q : 4'b0000;
  assign ram_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign ram_wdata = wdata_q;
  assign load_data = load_q;
  assign done      = (state_q == FIN);
  assign stall_req = rst_n & (accept | (state_q == REQ));
  assign addr_err  = addr_err_q;
  assign bus_err   = timeout;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: RAM responder with programmable
// ack delay plus a scoreboard of expected per-access results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, mem_read_flag, mem_write_flag, mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_write_data, mem_addr;
  logic        ram_req;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ack;
  logic [31:0] load_data;
  logic        done, stall_req, addr_err, bus_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] load;
    int          stalls;
    int          reqs;
    int          berr;
    int          berr_at;
    int          aerr;
    int          dones;
  } exp_t;

  exp_t sb_q[$];

  mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
    .mem_write_data(mem_write_data), .mem_addr(mem_addr),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .load_data(load_data), .done(done), .stall_req(stall_req),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t make_exp(input logic [3:0] we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] load,
                                    input int stalls, input int reqs, input int berr,
                                    input int berr_at, input int aerr, input int dones);
    exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.load = load;
    e.stalls = stalls; e.reqs = reqs; e.berr = berr; e.berr_at = berr_at;
    e.aerr = aerr; e.dones = dones;
    return e;
  endfunction

  // Drives one access, plays the RAM (ack after ack_wait idle REQ cycles, never
  // if negative), then pops the scoreboard entry and compares what was seen.
  task automatic applyStimulus(input string name, input logic rd, input logic wr, input logic sx,
                               input logic [3:0] sel, input logic [31:0] wd, input logic [31:0] addr,
                               input int ack_wait, input logic [31:0] rdata, input exp_t e);
    exp_t        x;
    int          stalls = 0, reqs = 0, berr = 0, berr_at = 0, aerr = 0, dones = 0, req_n = 0;
    logic [3:0]  we_s = 4'b0;
    logic [31:0] addr_s = 32'b0, wd_s = 32'b0, load_s = 32'b0;
    bit          finished = 1'b0;
    @(posedge clk); #1;
    sb_q.push_back(e);
    in_valid = 1'b1; mem_read_flag = rd; mem_write_flag = wr; mem_sign_ext_flag = sx;
    mem_sel = sel; mem_write_data = wd; mem_addr = addr; ram_ack = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      if (stall_req) stalls++;
      if (ram_req) begin
        reqs++;
        if (reqs == 1) begin we_s = ram_we; addr_s = ram_addr; wd_s = ram_wdata; end
      end
      if (bus_err) begin berr++; berr_at = req_n; end
      if (addr_err) aerr++;
      if (done) begin dones++; load_s = load_data; finished = 1'b1; end
      if (e.dones == 0 && cyc == 3) finished = 1'b1;
      @(posedge clk); #1;
      if (ram_req) begin
        req_n++;
        ram_ack   = (ack_wait >= 0) && (req_n > ack_wait);
        ram_rdata = ram_ack ? rdata : $urandom;
      end else begin
        ram_ack = 1'b0;
      end
      if (done || !stall_req) in_valid = 1'b0;
    end
    @(negedge clk);
    if (done) dones++;
    if (ram_req) reqs++;
    if (!finished) checkOutput({name, "_budget"}, 32'd0, 32'd1);
    in_valid = 1'b0; mem_read_flag = 1'b0; mem_write_flag = 1'b0;
    x = sb_q.pop_front();
    if (x.reqs > 0) begin
      checkOutput({name, "_we"}, {28'b0, we_s}, {28'b0, x.we});
      checkOutput({name, "_addr"}, addr_s, x.addr);
      if (wr) checkOutput({name, "_wdata"}, wd_s, x.wdata);
    end
    if (rd && !wr && x.dones > 0) checkOutput({name, "_load"}, load_s, x.load);
    checkOutput({name, "_stalls"}, stalls, x.stalls);
    checkOutput({name, "_reqs"}, reqs, x.reqs);
    checkOutput({name, "_dones"}, dones, x.dones);
    checkOutput({name, "_aerr"}, aerr, x.aerr);
    checkOutput({name, "_berr"}, berr, x.berr);
    if (x.berr > 0) checkOutput({name, "_berr_at"}, berr_at, x.berr_at);
  endtask

  initial begin
    int extra_done;
    rst_n = 1'b0; in_valid = 1'b0; mem_read_flag = 1'b0; mem_write_flag = 1'b0;
    mem_sign_ext_flag = 1'b0; mem_sel = 4'b0; mem_write_data = 32'b0; mem_addr = 32'b0;
    ram_rdata = 32'b0; ram_ack = 1'b0;
    #12;
    checkOutput("rst_ram_req", {31'b0, ram_req}, 32'd0);
    checkOutput("rst_ram_we", {28'b0, ram_we}, 32'd0);
    checkOutput("rst_ram_addr", ram_addr, 32'd0);
    checkOutput("rst_ram_wdata", ram_wdata, 32'd0);
    checkOutput("rst_load", load_data, 32'd0);
    checkOutput("rst_flags", {27'b0, done, stall_req, addr_err, bus_err, 1'b0}, 32'd0);
    #8 rst_n = 1'b1;

    applyStimulus("sw", 1'b0, 1'b1, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h100, 0, 32'h0,
                  make_exp(4'b1111, 32'h100, 32'hDEADBEEF, 32'h0, 2, 1, 0, 0, 0, 1));
    applyStimulus("sb", 1'b0, 1'b1, 1'b0, 4'b0001, 32'h000000A5, 32'h103, 0, 32'h0,
                  make_exp(4'b1000, 32'h100, 32'hA5A5A5A5, 32'h0, 2, 1, 0, 0, 0, 1));
    applyStimulus("lb", 1'b1, 1'b0, 1'b1, 4'b0001, 32'h0, 32'h202, 3, 32'h12F03456,
                  make_exp(4'b0000, 32'h200, 32'h0, 32'hFFFFFFF0, 5, 4, 0, 0, 0, 1));
    applyStimulus("lbu", 1'b1, 1'b0, 1'b0, 4'b0001, 32'h0, 32'h202, 3, 32'h12F03456,
                  make_exp(4'b0000, 32'h200, 32'h0, 32'h000000F0, 5, 4, 0, 0, 0, 1));
    applyStimulus("lb_lane1", 1'b1, 1'b0, 1'b1, 4'b0001, 32'h0, 32'h011, 0, 32'hAA5B7F80,
                  make_exp(4'b0000, 32'h010, 32'h0, 32'h0000007F, 2, 1, 0, 0, 0, 1));
    applyStimulus("lw_mis", 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h305, 0, 32'h0,
                  make_exp(4'b0000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0));
    applyStimulus("lw", 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h304, 1, 32'hCAFEF00D,
                  make_exp(4'b0000, 32'h304, 32'h0, 32'hCAFEF00D, 3, 2, 0, 0, 0, 1));
    applyStimulus("tmo", 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h040, -1, 32'h0,
                  make_exp(4'b0000, 32'h040, 32'h0, 32'h0, 256, 255, 1, 255, 0, 1));

    // Reset in the middle of an outstanding access, with the pipeline still holding it.
    @(posedge clk); #1;
    in_valid = 1'b1; mem_write_flag = 1'b1; mem_read_flag = 1'b0; mem_sel = 4'b1111;
    mem_addr = 32'h80; mem_write_data = 32'h11; ram_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_mid_pre_req", {31'b0, ram_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_req", {31'b0, ram_req}, 32'd0);
    checkOutput("rst_mid_stall", {31'b0, stall_req}, 32'd0);
    checkOutput("rst_mid_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; mem_write_flag = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    extra_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || ram_req) extra_done++;
    end
    checkOutput("rst_mid_quiet", extra_done, 32'd0);
    applyStimulus("lw_after_rst", 1'b1, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0, 0, 32'h89ABCDEF,
                  make_exp(4'b0000, 32'h0, 32'h0, 32'h89ABCDEF, 2, 1, 0, 0, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
